// File: rtl/tdc_therm_decoder.sv
// tdc_therm_decoder: sequences one TDC conversion at a time. It presets the
// delay chain, lets it settle, and synchronises the thermometer bits into clk.
// It then counts the ones, correcting for the chain's alternating polarity,
// re-arms the chain, and offers the code over a valid/ready handshake.
// Optional build macro: TDC_BUBBLE_FIX_EN adds a 3-tap majority filter ahead
// of the popcount, which costs one extra DECODE cycle.
module tdc_therm_decoder #(
  parameter int N_STAGE    = 32,
  parameter int OUT_W      = 6,
  parameter int SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic               restart,
  input  logic [N_STAGE-1:0] ff_vec,
  output logic               pstb_out,
  output logic               clk_phase_reverse,
  output logic [OUT_W-1:0]   code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE, PRESET, SETTLE, SAMPLE, DECODE, PULSE, DONE
  } state_t;

`ifdef TDC_BUBBLE_FIX_EN
  localparam logic [3:0] DECODE_CYC = 4'd2;
`else
  localparam logic [3:0] DECODE_CYC = 4'd1;
`endif

  state_t             state, next_state;
  logic [3:0]         cnt;
  logic [3:0]         stage_len;
  logic               last_cyc;
  logic               pol;
  logic               need_preset;
  logic [N_STAGE-1:0] sync1, sync2;
  logic [N_STAGE-1:0] dec_in;
  logic [OUT_W-1:0]   ones;
  logic [OUT_W-1:0]   code_next;
  logic               pstb_d, cpr_d, valid_d, busy_d;

  // The popcount is at most N_STAGE, and OUT_W is sized so that N_STAGE fits.
  // So both the count and N_STAGE-ones are exact in OUT_W bits and never wrap.
  function automatic logic [OUT_W-1:0] popcount(input logic [N_STAGE-1:0] v);
    logic [OUT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_STAGE; i++) acc = acc + OUT_W'(v[i]);
    return acc;
  endfunction

  // State register and per-state cycle counter.
  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (!rstb) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else if (!last_cyc)      cnt <= cnt + 4'd1;
    end
  end

  // Next-state logic; multi-cycle states leave on their last counted cycle.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    next_state = state;
    stage_len  = 4'd1;
    case (state)
      PRESET:  stage_len = 4'd2;
      SETTLE:  stage_len = 4'(SETTLE_CYC);
      SAMPLE:  stage_len = 4'd2;
      DECODE:  stage_len = DECODE_CYC;
      default: stage_len = 4'd1;
    endcase
    last_cyc = (cnt == stage_len - 4'd1);
    case (state)
      IDLE:    if (start) next_state = (need_preset || restart) ? PRESET : SETTLE;
      PRESET:  if (last_cyc) next_state = SETTLE;
      SETTLE:  if (last_cyc) next_state = SAMPLE;
      SAMPLE:  if (last_cyc) next_state = DECODE;
      DECODE:  if (last_cyc) next_state = PULSE;
      PULSE:   next_state = DONE;
      DONE:    if (code_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state; registered below so pins are glitch-free.
  always_comb begin
    pstb_d  = (next_state != PRESET);
    cpr_d   = (next_state == PULSE);
    valid_d = (next_state == DONE);
    busy_d  = (next_state != IDLE) && (next_state != DONE);
  end

  // Output registers; the chain is held in preset while rstb is low.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pstb_out          <= 1'b0;
      clk_phase_reverse <= 1'b0;
      code_valid        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      pstb_out          <= pstb_d;
      clk_phase_reverse <= cpr_d;
      code_valid        <= valid_d;
      busy              <= busy_d;
    end
  end

  // A restart arriving at any time is remembered until a preset consumes it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      need_preset <= 1'b1;
      pol         <= 1'b0;
    end else begin
      if (restart)              need_preset <= 1'b1;
      else if (state == PRESET) need_preset <= 1'b0;
      if (state == PRESET)      pol <= 1'b0;
      else if (state == PULSE)  pol <= ~pol;
    end
  end

  // Two-flop synchroniser for the asynchronous chain outputs, clocked only in SAMPLE.
  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: the synchroniser is reset as well, so the first decode never sees X.
    if (!rstb) begin
      sync1 <= '0;
      sync2 <= '0;
    end else if (state == SAMPLE) begin
      sync1 <= ff_vec;
      sync2 <= sync1;
    end
  end

`ifdef TDC_BUBBLE_FIX_EN
  logic [N_STAGE-1:0] filt;
  logic [N_STAGE-1:0] nb_lo, nb_hi;
  // Each bit is voted against its neighbours, with the end taps duplicated.
  assign nb_lo = {sync2[N_STAGE-2:0], sync2[0]};
  assign nb_hi = {sync2[N_STAGE-1], sync2[N_STAGE-1:1]};

  // Majority-filter register, loaded in the first DECODE cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                              filt <= '0;
    else if (state == DECODE && cnt == 4'd0) filt <= (nb_lo & sync2) | (nb_lo & nb_hi) | (sync2 & nb_hi);
  end
  assign dec_in = filt;
`else
  assign dec_in = sync2;
`endif

  // After an odd number of re-arms the chain is inverted, so the count is reflected.
  always_comb begin
    ones      = popcount(dec_in);
    code_next = pol ? (OUT_W'(N_STAGE) - ones) : ones;
  end

  // The result register is loaded in the final DECODE cycle and held through DONE.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                          code <= '0;
    else if (state == DECODE && last_cyc) code <= code_next;
  end

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Directed testbench for tdc_therm_decoder with N_STAGE=8, OUT_W=4, SETTLE_CYC=2.
// Inputs are driven and outputs are sampled on the falling edge.
// Latencies are counted in rising edges from the edge that samples start.
module tb_tdc_therm_decoder;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       start = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] ff_vec = 8'h00;
  logic       pstb_out, clk_phase_reverse, code_valid, code_ready = 1'b0, busy;
  logic [3:0] code;

  int total = 0;
  int bad   = 0;

`ifdef TDC_BUBBLE_FIX_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  // PRESET 2 + SETTLE 2 + SAMPLE 2 + DECODE 1 + PULSE 1 edges until DONE; without preset, 2 fewer.
  localparam int LAT_PRE = 8 + EXTRA;
  localparam int LAT_NP  = 6 + EXTRA;

  tdc_therm_decoder #(.N_STAGE(8), .OUT_W(4), .SETTLE_CYC(2)) dut (
    .clk(clk), .rstb(rstb), .start(start), .restart(restart), .ff_vec(ff_vec),
    .pstb_out(pstb_out), .clk_phase_reverse(clk_phase_reverse), .code(code),
    .code_valid(code_valid), .code_ready(code_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one conversion and checks latency, preset width, the re-arm pulse and the code.
  // It acknowledges the result only if ack is set.
  task automatic run_conv(input string tag, input logic [7:0] ff, input bit rs, input bit mid_rs,
                          input int exp_lat, input int exp_pre, input logic [3:0] exp_code,
                          input bit ack);
    int lat, pre_cnt, cpr_cnt, cpr_k;
    lat = -1; cpr_cnt = 0; cpr_k = -1;
    @(negedge clk); ff_vec = ff; start = 1'b1; restart = rs;
    @(negedge clk); start = 1'b0; restart = 1'b0;
    pre_cnt = !pstb_out ? 1 : 0;
    check({tag, ".busy"}, busy, 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      restart = (mid_rs && k == 2);
      if (!pstb_out) pre_cnt++;
      if (clk_phase_reverse) begin cpr_cnt++; cpr_k = k; end
      if (code_valid) begin lat = k; break; end
    end
    restart = 1'b0;
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".preset_cycles"}, pre_cnt, exp_pre);
    check({tag, ".cpr_cycles"}, cpr_cnt, 1);
    check({tag, ".cpr_before_valid"}, cpr_k, exp_lat - 1);
    check({tag, ".code"}, code, exp_code);
    check({tag, ".busy_done"}, busy, 0);
    if (ack) begin
      code_ready = 1'b1;
      @(negedge clk); code_ready = 1'b0;
      check({tag, ".valid_cleared"}, code_valid, 0);
    end
  endtask

  initial begin
    int win_bad;
    // Reset values.
    #12;
    check("rst.pstb_out", pstb_out, 0);
    check("rst.cpr", clk_phase_reverse, 0);
    check("rst.code", code, 0);
    check("rst.code_valid", code_valid, 0);
    check("rst.busy", busy, 0);
    @(negedge clk); rstb = 1'b1;
    @(negedge clk);
    check("rst.pstb_rises", pstb_out, 1);

    // A ready pulse with no valid code must have no effect.
    code_ready = 1'b1;
    @(negedge clk); code_ready = 1'b0;
    check("idle_ready.valid", code_valid, 0);
    check("idle_ready.busy", busy, 0);

    // 1: the first conversion presets; pol=0 gives code=popcount(0F)=4, and pol flips to 1.
    run_conv("t1", 8'h0F, 1'b0, 1'b0, LAT_PRE, 2, 4'd4, 1'b0);
    @(negedge clk); code_ready = 1'b1;
    @(negedge clk); code_ready = 1'b0;
    check("t1.valid_cleared", code_valid, 0);

    // 2: no preset; pol=1 gives 8-3=5, and pol flips to 0. The result is held without acknowledge.
    run_conv("t2", 8'h07, 1'b0, 1'b0, LAT_NP, 0, 4'd5, 1'b0);

    // 3: ready stays low for 10 cycles while a start pulse arrives mid-window.
    win_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (code_valid !== 1'b1 || code !== 4'd5 || busy !== 1'b0 ||
          pstb_out !== 1'b1 || clk_phase_reverse !== 1'b0) win_bad++;
      start = (i == 3);
    end
    start = 1'b0;
    check("t3.hold_window_violations", win_bad, 0);
    check("t3.code_held", code, 5);
    // Ready and start arrive together: start is dropped (one-cycle bubble).
    code_ready = 1'b1; start = 1'b1;
    @(negedge clk); code_ready = 1'b0; start = 1'b0;
    check("t3.bubble_valid", code_valid, 0);
    @(negedge clk);
    check("t3.bubble_busy", busy, 0);
    check("t3.bubble_pstb", pstb_out, 1);

    // 4: restart forces a preset, so pol=0 and FF gives 8; pol then flips to 1.
    run_conv("t4a", 8'hFF, 1'b1, 1'b0, LAT_PRE, 2, 4'd8, 1'b1);
    // pol=1, all zeros: 8-0=8; pol -> 0.
    run_conv("t4b", 8'h00, 1'b0, 1'b0, LAT_NP, 0, 4'd8, 1'b1);
    // pol=0, all zeros: 0; pol -> 1.
    run_conv("t4c", 8'h00, 1'b0, 1'b0, LAT_NP, 0, 4'd0, 1'b1);
    // pol=1, 3F: 8-6=2; a restart during the run is latched for the next start.
    run_conv("t4d", 8'h3F, 1'b0, 1'b1, LAT_NP, 0, 4'd2, 1'b1);
    // The latched restart causes a preset: pol=0, popcount(01)=1.
    run_conv("t4e", 8'h01, 1'b0, 1'b0, LAT_PRE, 2, 4'd1, 1'b1);

    // 5: pol=1 and no preset pending, so this start goes straight to SETTLE; reset there.
    @(negedge clk); ff_vec = 8'h0F; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t5.busy_settle", busy, 1);
    @(negedge clk); rstb = 1'b0;
    #1;
    check("t5.pstb_out", pstb_out, 0);
    check("t5.code_valid", code_valid, 0);
    check("t5.cpr", clk_phase_reverse, 0);
    check("t5.busy", busy, 0);
    check("t5.code", code, 0);
    @(negedge clk); rstb = 1'b1;
    @(negedge clk);
    check("t5.pstb_rises", pstb_out, 1);
    // After reset the next start presets again: pol=0, 0F gives 4.
    run_conv("t5b", 8'h0F, 1'b0, 1'b0, LAT_PRE, 2, 4'd4, 1'b1);

    // 6: bubbly code 0001_1011 with a forced preset (pol=0). Raw popcount is 4.
    // The majority filter fills bit 2 and gives 0001_1111 = 5.
`ifdef TDC_BUBBLE_FIX_EN
    run_conv("t6", 8'b0001_1011, 1'b1, 1'b0, LAT_PRE, 2, 4'd5, 1'b1);
`else
    run_conv("t6", 8'b0001_1011, 1'b1, 1'b0, LAT_PRE, 2, 4'd4, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
